// File: rtl/spi_mc_pkg.sv
// spi_mc_pkg: shared state encoding and SPI mode helpers for spi_master_mc.
package spi_mc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  typedef logic [1:0] spi_mode_t;

endpackage

// File: rtl/spi_mc_clkgen.sv
// spi_mc_clkgen: SCK half-period divider and SHIFT edge counter.
module spi_mc_clkgen #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic half_tick,
  output logic leading,
  output logic trailing,
  output logic last_edge
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDG_W = $clog2(2 * DATA_W);

  logic [DIV_W-1:0] div_q, div_d;
  logic [EDG_W-1:0] edge_q, edge_d;
  logic             step;

  always_comb begin
    half_tick = (div_q == DIV_W'(CLK_DIV - 1));
    step      = half_tick & en;
    // edge_q counts from 0, so even values are leading edges
    leading   = step & ~edge_q[0];
    trailing  = step & edge_q[0];
    last_edge = step & (edge_q == EDG_W'(2 * DATA_W - 1));
    div_d     = half_tick ? '0 : div_q + DIV_W'(1);
    edge_d    = step ? edge_q + EDG_W'(1) : edge_q;
    if (clr) begin
      div_d  = '0;
      edge_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      edge_q <= '0;
    end else begin
      div_q  <= div_d;
      edge_q <= edge_d;
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-select SPI master, all four modes, optional CS hold.
// Define SPI_MC_LSB_FIRST_EN to shift LSB first (default MSB first).
module spi_master_mc
  import spi_mc_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NUM_CS  = 2,
  parameter  int CLK_DIV = 4,
  localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [1:0]        mode,
  input  logic              hold_cs,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
`ifdef SPI_MC_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_W-1];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] tx_next(input logic [DATA_W-1:0] w);
`ifdef SPI_MC_LSB_FIRST_EN
    return {1'b0, w[DATA_W-1:1]};
`else
    return {w[DATA_W-2:0], 1'b0};
`endif
  endfunction

  function automatic logic [DATA_W-1:0] rx_next(input logic [DATA_W-1:0] w,
                                                input logic b);
`ifdef SPI_MC_LSB_FIRST_EN
    return {b, w[DATA_W-1:1]};
`else
    return {w[DATA_W-2:0], b};
`endif
  endfunction

  state_e            state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic              hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;

  logic accept;
  logic half_tick, leading, trailing, last_edge;
  logic sample_edge, shift_edge;

  assign accept = (state_q == IDLE) && start;

  spi_mc_clkgen #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .en        (state_q == SHIFT),
    .half_tick (half_tick),
    .leading   (leading),
    .trailing  (trailing),
    .last_edge (last_edge)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;

    // CPHA=0 samples on leading edges, CPHA=1 on trailing
    sample_edge = mode_q[CPHA_BIT] ? trailing : leading;
    shift_edge  = mode_q[CPHA_BIT] ? leading : trailing;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          mode_d  = mode;
          hold_d  = hold_cs;
          busy_d  = 1'b1;
          sck_d   = mode[CPOL_BIT];
          tx_d    = tx_data;
          rx_d    = '0;
          for (int i = 0; i < NUM_CS; i++) begin
            cs_n_d[i] = (cs_sel != CS_W'(i));
          end
          if (!mode[CPHA_BIT]) begin
            mosi_d = first_bit(tx_data);
            tx_d   = tx_next(tx_data);
          end
        end
      end
      SETUP: begin
        if (half_tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (half_tick) sck_d = ~sck_q;
        if (sample_edge) rx_d = rx_next(rx_q, miso);
        if (shift_edge && !last_edge) begin
          mosi_d = first_bit(tx_q);
          tx_d   = tx_next(tx_q);
        end
        if (last_edge) state_d = HOLD;
      end
      HOLD: begin
        if (half_tick) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_q;
          if (!hold_q) cs_n_d = '1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule
